// File: rtl/gray_ticket_arbiter.sv
// Round-robin arbiter that hands each winner a Gray-coded ticket
// from one shared binary sequence counter.
module gray_ticket_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             hold,
    input  logic             clear,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] ticket,
    output logic             ticket_vld,
    output logic             wrap,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] ticket_q, ticket_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;

    logic             found;
    logic [PW-1:0]    winner;

    // First set request at or above the pointer, wrapping at NREQ-1.
    always_comb begin : search
        int          idx;
        logic [PW-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        ticket_d = ticket_q;
        vld_d    = 1'b0;
        wrap_d   = 1'b0;
        unique case (state_q)
            CLEAR: begin
                count_d = '0;
                ptr_d   = '0;
                state_d = hold ? HOLD : RUN;
            end
            HOLD: begin
                if (clear) begin
                    state_d = CLEAR;
                end else if (!hold) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = CLEAR;
                end else if (hold) begin
                    state_d = HOLD;
                end else if (found) begin
                    gnt_d[winner] = 1'b1;
                    ticket_d      = count_q ^ (count_q >> 1);
                    vld_d         = 1'b1;
                    wrap_d        = &count_q;
                    count_d       = count_q + 1'b1;
                    ptr_d         = (winner == LAST) ? '0 : winner + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            count_q  <= '0;
            ticket_q <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ticket_q <= ticket_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            vld_q    <= vld_d;
            wrap_q   <= wrap_d;
        end
    end

    assign gnt        = gnt_q;
    assign ticket     = ticket_q;
    assign ticket_vld = vld_q;
    assign wrap       = wrap_q;
    assign busy       = (state_q != RUN);

endmodule
